// File: rtl/carry_select.sv
// rtl/carry_select.sv - registered 16-bit carry-select adder
//
// Purpose: 16-bit unsigned adder built from BLOCK_W-bit ripple-carry blocks.
//   Block 0 ripples with carry-in 0. Every higher block precomputes its sum
//   for both carry-in values, then a 2:1 mux picks one using the selected
//   carry-out of the block below. Sum and carry are registered with
//   exactly one cycle of latency.
//
// Parameters:
//   BLOCK_W   - block width in bits; 2, 4 or 8.
//
// Ports:
//   clk       - clock; all state updates on its rising edge.
//   rst       - synchronous active-high reset; clears all outputs.
//   operand1  - addend A, 16-bit unsigned.
//   operand2  - addend B, 16-bit unsigned.
//   Cout      - registered carry out of bit 15.
//   Result    - registered modulo-2^16 sum.
//   Ovf       - registered two's-complement overflow flag.
//               Present only when CARRY_SELECT_OVF_EN is defined.
//
// Optional feature macro: CARRY_SELECT_OVF_EN

module carry_select_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Each bit gets its own carry net. This keeps the chain free of
  // self-referencing vector bits.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_bit[i-1].co;
    end
    assign s[i] = a[i] ^ b[i] ^ ci;
    assign co   = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign cout = g_bit[W-1].co;

endmodule

module carry_select #(
  parameter int BLOCK_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] operand1,
  input  logic [15:0] operand2,
  output logic        Cout,
  output logic [15:0] Result
`ifdef CARRY_SELECT_OVF_EN
  ,
  output logic        Ovf
`endif
);

  localparam int NB = 16 / BLOCK_W;

  logic [15:0] sum;
  logic        carry_top;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [BLOCK_W-1:0] blk_a;
    logic [BLOCK_W-1:0] blk_b;
    logic               csel;  // selected carry-out of this block

    assign blk_a = operand1[k*BLOCK_W +: BLOCK_W];
    assign blk_b = operand2[k*BLOCK_W +: BLOCK_W];

    if (k == 0) begin : g_base
      logic [BLOCK_W-1:0] s0;
      logic               c0;

      carry_select_rca #(.W(BLOCK_W)) u_rca (
        .a    (blk_a),
        .b    (blk_b),
        .cin  (1'b0),
        .s    (s0),
        .cout (c0)
      );

      assign sum[k*BLOCK_W +: BLOCK_W] = s0;
      assign csel = c0;
    end else begin : g_sel
      logic [BLOCK_W-1:0] s0;
      logic [BLOCK_W-1:0] s1;
      logic               c0;
      logic               c1;
      logic               cin_sel;

      carry_select_rca #(.W(BLOCK_W)) u_rca0 (
        .a    (blk_a),
        .b    (blk_b),
        .cin  (1'b0),
        .s    (s0),
        .cout (c0)
      );

      carry_select_rca #(.W(BLOCK_W)) u_rca1 (
        .a    (blk_a),
        .b    (blk_b),
        .cin  (1'b1),
        .s    (s1),
        .cout (c1)
      );

      // The carry-in for the mux comes from the block below. That carry
      // was already selected, so the critical path crosses one mux per
      // block rather than one full ripple.
      assign cin_sel = g_blk[k-1].csel;
      assign sum[k*BLOCK_W +: BLOCK_W] = cin_sel ? s1 : s0;
      assign csel = cin_sel ? c1 : c0;
    end
  end

  assign carry_top = g_blk[NB-1].csel;

  always_ff @(posedge clk) begin
    if (rst) begin
      Cout   <= 1'b0;
      Result <= 16'h0000;
    end else begin
      Cout   <= carry_top;
      Result <= sum;
    end
  end

`ifdef CARRY_SELECT_OVF_EN
  // Signed overflow: both operands share a sign, and the sum's sign differs.
  logic ovf_next;
  assign ovf_next = (operand1[15] == operand2[15]) && (sum[15] != operand1[15]);

  always_ff @(posedge clk) begin
    if (rst) begin
      Ovf <= 1'b0;
    end else begin
      Ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_carry_select.sv
// tb/tb_carry_select.sv - directed self-checking bench for carry_select

module tb_carry_select;

  logic        clk;
  logic        rst;
  logic [15:0] operand1;
  logic [15:0] operand2;

  logic        cout2, cout4, cout8;
  logic [15:0] res2, res4, res8;
`ifdef CARRY_SELECT_OVF_EN
  logic        ovf2, ovf4, ovf8;
`endif

  int checks;
  int errors;

  carry_select #(.BLOCK_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .Cout     (cout2),
    .Result   (res2)
`ifdef CARRY_SELECT_OVF_EN
    ,
    .Ovf      (ovf2)
`endif
  );

  carry_select #(.BLOCK_W(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .Cout     (cout4),
    .Result   (res4)
`ifdef CARRY_SELECT_OVF_EN
    ,
    .Ovf      (ovf4)
`endif
  );

  carry_select #(.BLOCK_W(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .Cout     (cout8),
    .Result   (res8)
`ifdef CARRY_SELECT_OVF_EN
    ,
    .Ovf      (ovf8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors with hand-computed sums.
  localparam logic [15:0] VA   [4] = '{16'hA0A0, 16'h58F4, 16'h0F3D, 16'hC8CA};
  localparam logic [15:0] VB   [4] = '{16'hA0A0, 16'hF4F4, 16'h0F0F, 16'hC8CA};
  localparam logic [15:0] VRES [4] = '{16'h4140, 16'h4DE8, 16'h1E4C, 16'h9194};
  localparam logic        VC   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  // Overflow flag: operand signs match and the result sign differs.
  localparam logic        VOVF [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    rst = 1'b1;
    operand1 = 16'h1234;
    operand2 = 16'hFEDC;
    @(posedge clk); #1;
    checks++;
    if (cout4 !== 1'b0) begin
      errors++; $display("FAIL reset_cout: got %b expected 0", cout4);
    end
    checks++;
    if (res4 !== 16'h0000) begin
      errors++; $display("FAIL reset_result: got %h expected 0000", res4);
    end
    checks++;
    if (res8 !== 16'h0000 || res2 !== 16'h0000) begin
      errors++; $display("FAIL reset_result_w2_w8: got %h/%h expected 0000", res2, res8);
    end
`ifdef CARRY_SELECT_OVF_EN
    checks++;
    if (ovf4 !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b expected 0", ovf4);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 4; i++) begin
      operand1 = VA[i];
      operand2 = VB[i];
      @(posedge clk); #1;
      checks++;
      if (cout4 !== VC[i]) begin
        errors++; $display("FAIL vec%0d_cout: got %b expected %b", i, cout4, VC[i]);
      end
      checks++;
      if (res4 !== VRES[i]) begin
        errors++; $display("FAIL vec%0d_result: got %h expected %h", i, res4, VRES[i]);
      end
`ifdef CARRY_SELECT_OVF_EN
      checks++;
      if (ovf4 !== VOVF[i]) begin
        errors++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf4, VOVF[i]);
      end
`endif
    end
  endtask

  task automatic test_full_carry();
    operand1 = 16'hFFFF;
    operand2 = 16'h0001;
    @(posedge clk); #1;
    checks++;
    if (cout2 !== 1'b1 || res2 !== 16'h0000) begin
      errors++; $display("FAIL full_carry_w2: got %b/%h expected 1/0000", cout2, res2);
    end
    checks++;
    if (cout4 !== 1'b1 || res4 !== 16'h0000) begin
      errors++; $display("FAIL full_carry_w4: got %b/%h expected 1/0000", cout4, res4);
    end
    checks++;
    if (cout8 !== 1'b1 || res8 !== 16'h0000) begin
      errors++; $display("FAIL full_carry_w8: got %b/%h expected 1/0000", cout8, res8);
    end
`ifdef CARRY_SELECT_OVF_EN
    checks++;
    if (ovf4 !== 1'b0) begin
      errors++; $display("FAIL full_carry_ovf: got %b expected 0", ovf4);
    end
`endif
    // A carry that enters the top block alone.
    operand1 = 16'h7FFF;
    operand2 = 16'h0001;
    @(posedge clk); #1;
    checks++;
    if (cout2 !== 1'b0 || res2 !== 16'h8000 || res8 !== 16'h8000) begin
      errors++; $display("FAIL top_block_carry: got %b/%h/%h expected 0/8000/8000", cout2, res2, res8);
    end
  endtask

  task automatic test_back_to_back();
    // A new operand pair is applied every cycle. Each result must hold
    // until the following edge.
    for (int i = 0; i < 4; i++) begin
      operand1 = VA[3-i];
      operand2 = VB[3-i];
      @(posedge clk); #1;
      if (i < 3) begin
        operand1 = VA[2-i];
        operand2 = VB[2-i];
      end
      checks++;
      if (res2 !== VRES[3-i] || cout2 !== VC[3-i]) begin
        errors++; $display("FAIL b2b%0d_w2: got %b/%h expected %b/%h", i, cout2, res2, VC[3-i], VRES[3-i]);
      end
      #3;
      checks++;
      if (res8 !== VRES[3-i] || cout8 !== VC[3-i]) begin
        errors++; $display("FAIL b2b%0d_hold_w8: got %b/%h expected %b/%h", i, cout8, res8, VC[3-i], VRES[3-i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    operand1 = 16'h0F3D;
    operand2 = 16'h0F0F;
    @(posedge clk); #1;
    operand1 = 16'hFFFF;
    operand2 = 16'hFFFF;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cout4 !== 1'b0 || res4 !== 16'h0000) begin
      errors++; $display("FAIL mid_reset_clear: got %b/%h expected 0/0000", cout4, res4);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cout4 !== 1'b1 || res4 !== 16'hFFFE) begin
      errors++; $display("FAIL post_reset_w4: got %b/%h expected 1/fffe", cout4, res4);
    end
    checks++;
    if (cout2 !== 1'b1 || res2 !== 16'hFFFE || cout8 !== 1'b1 || res8 !== 16'hFFFE) begin
      errors++; $display("FAIL post_reset_w2_w8: got %b/%h %b/%h expected 1/fffe", cout2, res2, cout8, res8);
    end
`ifdef CARRY_SELECT_OVF_EN
    checks++;
    if (ovf4 !== 1'b0) begin
      errors++; $display("FAIL post_reset_ovf: got %b expected 0", ovf4);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    operand1 = 16'h0000;
    operand2 = 16'h0000;
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_full_carry();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
